// File: rtl/cycle_timer.sv
`default_nettype none
// ============================================================================
// Module      : cycle_timer
// Description : Free-running 64-bit machine timer with compare IRQ, prescaled
//               tick strobe and a word-addressed register port.
// Revision    : 1.0 - initial release
// ============================================================================
module cycle_timer #(
    parameter int          PRESC_W = 16,
    parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        WE,
    input  logic        RE,
    input  logic [2:0]  ADDR,
    input  logic [31:0] WDATA,
    output logic [31:0] RDATA,
    output logic        READY,
    output logic        TICK,
    output logic        IRQ
);

    localparam logic [2:0] c_ADDR_MTIME_LO = 3'd0;
    localparam logic [2:0] c_ADDR_MTIME_HI = 3'd1;
    localparam logic [2:0] c_ADDR_CMP_LO   = 3'd2;
    localparam logic [2:0] c_ADDR_CMP_HI   = 3'd3;
    localparam logic [2:0] c_ADDR_CTRL     = 3'd4;

    logic [63:0]        r_mtime;
    logic [63:0]        r_cmp;
    logic               r_en;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_pcnt;
    logic [31:0]        r_shadow;
    logic [31:0]        r_rdata;
    logic               r_ready;
    logic               r_tick;
    logic               r_irq;

    logic               w_wr_lo;
    logic               w_wr_hi;
    logic               w_wr_cmp_lo;
    logic               w_wr_cmp_hi;
    logic               w_wr_ctrl;
    logic               w_inc;
    logic [31:0]        w_ctrl;
    logic [31:0]        w_rd_mux;

    assign w_wr_lo     = WE && (ADDR == c_ADDR_MTIME_LO);
    assign w_wr_hi     = WE && (ADDR == c_ADDR_MTIME_HI);
    assign w_wr_cmp_lo = WE && (ADDR == c_ADDR_CMP_LO);
    assign w_wr_cmp_hi = WE && (ADDR == c_ADDR_CMP_HI);
    assign w_wr_ctrl   = WE && (ADDR == c_ADDR_CTRL);

    assign w_inc  = r_en && (r_pcnt == r_presc);
    assign w_ctrl = 32'({r_presc, r_en});

    // mtime_hi returns the shadow so a lo-then-hi pair is coherent
    always_comb begin
        w_rd_mux = 32'd0;
        case (ADDR)
            c_ADDR_MTIME_LO: w_rd_mux = r_mtime[31:0];
            c_ADDR_MTIME_HI: w_rd_mux = r_shadow;
            c_ADDR_CMP_LO:   w_rd_mux = r_cmp[31:0];
            c_ADDR_CMP_HI:   w_rd_mux = r_cmp[63:32];
            c_ADDR_CTRL:     w_rd_mux = w_ctrl;
            default:         w_rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_mtime  <= 64'd0;
            r_cmp    <= CMP_RST;
            r_en     <= 1'b0;
            r_presc  <= '0;
            r_pcnt   <= '0;
            r_shadow <= 32'd0;
            r_rdata  <= 32'd0;
            r_ready  <= 1'b0;
            r_tick   <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            // software writes to mtime take priority over the increment
            if (w_wr_lo) begin
                r_mtime[31:0] <= WDATA;
            end else if (w_wr_hi) begin
                r_mtime[63:32] <= WDATA;
            end else if (w_inc) begin
                r_mtime <= r_mtime + 64'd1;
            end

            if (w_wr_cmp_lo) begin
                r_cmp[31:0] <= WDATA;
            end
            if (w_wr_cmp_hi) begin
                r_cmp[63:32] <= WDATA;
            end

            if (w_wr_ctrl) begin
                r_en    <= WDATA[0];
                r_presc <= WDATA[PRESC_W:1];
                r_pcnt  <= '0;
            end else if (r_en) begin
                r_pcnt <= w_inc ? '0 : r_pcnt + PRESC_W'(1);
            end

            r_tick <= w_inc;
            r_irq  <= (r_mtime >= r_cmp);

            // read data reflects state before any write on the same edge
            if (RE) begin
                r_ready <= 1'b1;
                r_rdata <= w_rd_mux;
                if (ADDR == c_ADDR_MTIME_LO) begin
                    r_shadow <= r_mtime[63:32];
                end
            end else begin
                r_ready <= 1'b0;
            end
        end
    end

    assign RDATA = r_rdata;
    assign READY = r_ready;
    assign TICK  = r_tick;
    assign IRQ   = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cycle_timer
// Description : Self-checking bench for cycle_timer (vector table + read queue).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cycle_timer;

    logic        CLK;
    logic        RST_N;
    logic        WE;
    logic        RE;
    logic [2:0]  ADDR;
    logic [31:0] WDATA;
    logic [31:0] RDATA;
    logic        READY;
    logic        TICK;
    logic        IRQ;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        we;
        logic        re;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] exp;
    } rd_exp_t;

    vec_t    tbl[$];
    rd_exp_t sb[$];

    cycle_timer #(
        .PRESC_W (16),
        .CMP_RST (64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .WE    (WE),
        .RE    (RE),
        .ADDR  (ADDR),
        .WDATA (WDATA),
        .RDATA (RDATA),
        .READY (READY),
        .TICK  (TICK),
        .IRQ   (IRQ)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic re, input logic [2:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp);
        vec_t v;
        v.we = we; v.re = re; v.addr = addr; v.wdata = wdata; v.exp = exp;
        return v;
    endfunction

    // Read responses are matched in order against the queue
    always @(negedge CLK) begin
        if (RST_N && READY) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", {63'd0, READY}, 64'd0);
            end else begin
                rd_exp_t e;
                e = sb.pop_front();
                chk($sformatf("read_addr%0d", e.addr), {32'd0, RDATA}, {32'd0, e.exp});
            end
        end
    end

    // All tasks start and end just after a falling edge
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        WE = 1'b1; ADDR = a; WDATA = d;
        @(negedge CLK);
        WE = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp);
        rd_exp_t e;
        RE = 1'b1; ADDR = a;
        e.addr = a; e.exp = exp;
        sb.push_back(e);
        @(negedge CLK);
        RE = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_exp_t e;
        RST_N = 1'b0; WE = 1'b0; RE = 1'b0; ADDR = 3'd0; WDATA = 32'd0;
        #2;
        chk("rst_rdata", {32'd0, RDATA}, 64'd0);
        chk("rst_ready", {63'd0, READY}, 64'd0);
        chk("rst_tick",  {63'd0, TICK},  64'd0);
        chk("rst_irq",   {63'd0, IRQ},   64'd0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        // Register map vectors with the timer stopped
        tbl.push_back(mk(0, 1, 3'd0, 32'h0, 32'h0000_0000));
        tbl.push_back(mk(0, 1, 3'd1, 32'h0, 32'h0000_0000));
        tbl.push_back(mk(0, 1, 3'd2, 32'h0, 32'hFFFF_FFFF));
        tbl.push_back(mk(0, 1, 3'd3, 32'h0, 32'hFFFF_FFFF));
        tbl.push_back(mk(0, 1, 3'd4, 32'h0, 32'h0000_0000));
        tbl.push_back(mk(0, 1, 3'd5, 32'h0, 32'h0000_0000));
        tbl.push_back(mk(1, 0, 3'd2, 32'h1234_5678, 32'h0));
        tbl.push_back(mk(1, 0, 3'd3, 32'h0000_0009, 32'h0));
        tbl.push_back(mk(0, 1, 3'd2, 32'h0, 32'h1234_5678));
        tbl.push_back(mk(0, 1, 3'd3, 32'h0, 32'h0000_0009));
        tbl.push_back(mk(1, 0, 3'd4, 32'hFFFF_FFFE, 32'h0));
        tbl.push_back(mk(0, 1, 3'd4, 32'h0, 32'h0001_FFFE));
        tbl.push_back(mk(1, 0, 3'd4, 32'h0, 32'h0));
        tbl.push_back(mk(0, 1, 3'd4, 32'h0, 32'h0000_0000));
        tbl.push_back(mk(1, 0, 3'd7, 32'hDEAD_BEEF, 32'h0));
        tbl.push_back(mk(0, 1, 3'd7, 32'h0, 32'h0000_0000));
        tbl.push_back(mk(1, 0, 3'd0, 32'hAAAA_5555, 32'h0));
        tbl.push_back(mk(1, 0, 3'd1, 32'h0000_1234, 32'h0));
        tbl.push_back(mk(0, 1, 3'd1, 32'h0, 32'h0000_0000));
        tbl.push_back(mk(0, 1, 3'd0, 32'h0, 32'hAAAA_5555));
        tbl.push_back(mk(0, 1, 3'd1, 32'h0, 32'h0000_1234));
        tbl.push_back(mk(1, 0, 3'd0, 32'h0, 32'h0));
        tbl.push_back(mk(1, 0, 3'd1, 32'h0, 32'h0));
        tbl.push_back(mk(1, 0, 3'd2, 32'hFFFF_FFFF, 32'h0));
        tbl.push_back(mk(1, 0, 3'd3, 32'hFFFF_FFFF, 32'h0));
        tbl.push_back(mk(0, 1, 3'd6, 32'h0, 32'h0000_0000));

        for (int i = 0; i < tbl.size(); i++) begin
            WE = tbl[i].we; RE = tbl[i].re; ADDR = tbl[i].addr; WDATA = tbl[i].wdata;
            if (tbl[i].re) begin
                e.addr = tbl[i].addr; e.exp = tbl[i].exp;
                sb.push_back(e);
            end
            @(negedge CLK);
            WE = 1'b0; RE = 1'b0;
        end

        // Reset mid-count with a read in flight
        wr(3'd4, 32'h1);
        repeat (5) @(negedge CLK);
        RE = 1'b1; ADDR = 3'd0;
        @(posedge CLK);
        #1;
        chk("pre_rst_ready", {63'd0, READY}, 64'd1);
        chk("pre_rst_rdata", {32'd0, RDATA}, 64'd5);
        RST_N = 1'b0; RE = 1'b0;
        #1;
        chk("midrst_ready", {63'd0, READY}, 64'd0);
        chk("midrst_rdata", {32'd0, RDATA}, 64'd0);
        chk("midrst_tick",  {63'd0, TICK},  64'd0);
        chk("midrst_irq",   {63'd0, IRQ},   64'd0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        rd(3'd0, 32'd0);
        rd(3'd4, 32'd0);
        chk("post_rst_irq", {63'd0, IRQ}, 64'd0);

        // PRESC=0: one increment per cycle
        wr(3'd4, 32'h1);
        chk("p0_tick_first", {63'd0, TICK}, 64'd0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            chk($sformatf("p0_tick_%0d", k), {63'd0, TICK}, 64'd1);
        end
        rd(3'd0, 32'd10);

        // PRESC=3: one increment every 4 cycles, then freeze
        wr(3'd4, 32'h0);
        wr(3'd0, 32'h0);
        wr(3'd1, 32'h0);
        wr(3'd4, 32'h7);
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            chk($sformatf("p3_tick_%0d", k), {63'd0, TICK}, {63'd0, (k % 4) == 0});
        end
        rd(3'd0, 32'd5);
        wr(3'd4, 32'h6);
        chk("rdata_hold", {32'd0, RDATA}, 64'd5);
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            chk($sformatf("frozen_tick_%0d", k), {63'd0, TICK}, 64'd0);
        end
        rd(3'd0, 32'd5);

        // Coherent read across lo->hi carry
        wr(3'd4, 32'h0);
        wr(3'd0, 32'hFFFF_FFFE);
        wr(3'd1, 32'h0);
        wr(3'd4, 32'h1);
        @(negedge CLK);
        rd(3'd0, 32'hFFFF_FFFF);
        repeat (2) @(negedge CLK);
        rd(3'd1, 32'h0);
        rd(3'd0, 32'h0000_0003);
        rd(3'd1, 32'h0000_0001);

        // 64-bit wrap and IRQ on equality
        wr(3'd4, 32'h0);
        wr(3'd0, 32'hFFFF_FFFF);
        wr(3'd1, 32'hFFFF_FFFF);
        wr(3'd4, 32'h1);
        chk("irq_equal", {63'd0, IRQ}, 64'd1);
        @(negedge CLK);
        rd(3'd0, 32'h0);
        chk("irq_after_wrap", {63'd0, IRQ}, 64'd0);
        rd(3'd1, 32'h0);

        // IRQ at cmp=100
        wr(3'd4, 32'h0);
        wr(3'd0, 32'h0);
        wr(3'd1, 32'h0);
        wr(3'd2, 32'd100);
        wr(3'd3, 32'h0);
        wr(3'd4, 32'h1);
        for (int k = 1; k <= 101; k++) begin
            @(negedge CLK);
            if (k == 99 || k == 100) chk($sformatf("irq_low_%0d", k), {63'd0, IRQ}, 64'd0);
            if (k == 101)            chk("irq_rise", {63'd0, IRQ}, 64'd1);
        end
        wr(3'd3, 32'h1);
        chk("irq_still_high", {63'd0, IRQ}, 64'd1);
        @(negedge CLK);
        chk("irq_drop", {63'd0, IRQ}, 64'd0);

        // Write over increment with simultaneous read of the old value
        WE = 1'b1; RE = 1'b1; ADDR = 3'd0; WDATA = 32'h50;
        e.addr = 3'd0; e.exp = 32'd103;
        sb.push_back(e);
        @(negedge CLK);
        WE = 1'b0; RE = 1'b0;
        rd(3'd0, 32'h50);
        rd(3'd0, 32'h51);
        rd(3'd1, 32'h0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge CLK);
        chk("scoreboard_drain", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
